// File: rtl/fetch_sequencer_if.sv
// Memory read port and decoder handshake between the fetch sequencer (master)
// and its memory/decoder neighbours (slave).
interface fetch_sequencer_if #(
    parameter int REG_WIDTH  = 8,
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_rd;
    logic [REG_WIDTH-1:0]  mem_data;
    logic                  mem_rvalid;
    logic [REG_WIDTH-1:0]  instruction;
    logic [REG_WIDTH-1:0]  operand;
    logic [ADDR_WIDTH-1:0] eff_addr;
    logic                  instruction_ready;
    logic                  instruction_done;

    modport master (
        output mem_addr, mem_rd, instruction, operand, eff_addr, instruction_ready,
        input  mem_data, mem_rvalid, instruction_done
    );

    modport slave (
        input  mem_addr, mem_rd, instruction, operand, eff_addr, instruction_ready,
        output mem_data, mem_rvalid, instruction_done
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch front end: reads opcode and operand bytes, chases zero-page pointers,
// resolves the effective address and hands the instruction to the decoder.
module fetch_sequencer #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 16'h0600
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  run,
    input  logic [REG_WIDTH-1:0]  x_in,
    input  logic [REG_WIDTH-1:0]  y_in,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  fault,
    fetch_sequencer_if.master     bus
);

    typedef enum logic [3:0] {
        IDLE, FETCH_OP, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, ISSUE, WAIT_DONE, HALT
    } state_e;

    typedef enum logic [3:0] {
        AM_IMPL, AM_IMM, AM_REL, AM_ZPG, AM_ZPX, AM_ABS, AM_ABX, AM_ABY,
        AM_INDX, AM_INDY, AM_ILLEGAL
    } amode_e;

    function automatic amode_e decode_mode(input logic [REG_WIDTH-1:0] op);
        amode_e m;
        m = AM_IMPL;
        if (op[1:0] == 2'b11) begin
            m = AM_ILLEGAL;
        end else if (op[1:0] == 2'b01) begin
            case (op[4:2])
                3'b000:  m = AM_INDX;
                3'b001:  m = AM_ZPG;
                3'b010:  m = AM_IMM;
                3'b011:  m = AM_ABS;
                3'b100:  m = AM_INDY;
                3'b101:  m = AM_ZPX;
                3'b110:  m = AM_ABY;
                default: m = AM_ABX;
            endcase
        end else begin
            // This revision indexes everything in this group with X.
            case (op[4:2])
                3'b000:  m = AM_IMM;
                3'b001:  m = AM_ZPG;
                3'b010:  m = AM_IMPL;
                3'b011:  m = AM_ABS;
                3'b100:  m = AM_REL;
                3'b101:  m = AM_ZPX;
                3'b110:  m = AM_IMPL;
                default: m = AM_ABX;
            endcase
        end
        return m;
    endfunction

    state_e                r_state,       w_state;
    logic [ADDR_WIDTH-1:0] r_pc,          w_pc;
    logic [REG_WIDTH-1:0]  r_instruction, w_instruction;
    logic [REG_WIDTH-1:0]  r_operand,     w_operand;
    logic [ADDR_WIDTH-1:0] r_eff_addr,    w_eff_addr;
    logic                  r_ready,       w_ready;
    logic                  r_fault,       w_fault;
    logic [REG_WIDTH-1:0]  r_lo,          w_lo;
    logic [REG_WIDTH-1:0]  r_ptr,         w_ptr;

    logic                  w_mem_rd;
    logic [ADDR_WIDTH-1:0] w_mem_addr;
    amode_e                w_new_mode;
    amode_e                w_cur_mode;
    logic [REG_WIDTH-1:0]  w_zpx;
    logic [REG_WIDTH-1:0]  w_ptr_next;
    logic [REG_WIDTH-1:0]  w_abs_idx;
    logic [REG_WIDTH-1:0]  w_ind_idx;
    logic [ADDR_WIDTH-1:0] w_abs_sum;
    logic [ADDR_WIDTH-1:0] w_ind_sum;

    assign w_new_mode = decode_mode(bus.mem_data);
    assign w_cur_mode = decode_mode(r_instruction);

    // Byte-wide sums wrap inside the zero page and never carry into the high byte.
    assign w_zpx      = bus.mem_data + x_in;
    assign w_ptr_next = r_ptr + 1'b1;
    assign w_abs_idx  = (w_cur_mode == AM_ABY) ? y_in
                      : (w_cur_mode == AM_ABX) ? x_in : '0;
    assign w_ind_idx  = (w_cur_mode == AM_INDY) ? y_in : '0;
    assign w_abs_sum  = ADDR_WIDTH'({bus.mem_data, r_lo}) + ADDR_WIDTH'(w_abs_idx);
    assign w_ind_sum  = ADDR_WIDTH'({bus.mem_data, r_lo}) + ADDR_WIDTH'(w_ind_idx);

    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_instruction = r_instruction;
        w_operand     = r_operand;
        w_eff_addr    = r_eff_addr;
        w_ready       = r_ready;
        w_fault       = r_fault;
        w_lo          = r_lo;
        w_ptr         = r_ptr;
        w_mem_rd      = 1'b0;
        w_mem_addr    = '0;

        case (r_state)
            IDLE: begin
                if (run) w_state = FETCH_OP;
            end
            FETCH_OP: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_pc;
                if (bus.mem_rvalid) begin
                    w_instruction = bus.mem_data;
                    w_pc          = r_pc + 1'b1;
                    w_operand     = '0;
                    w_eff_addr    = '0;
                    if (w_new_mode == AM_ILLEGAL) begin
                        w_fault = 1'b1;
                        w_state = HALT;
                    end else if (w_new_mode == AM_IMPL) begin
                        w_state = ISSUE;
                    end else begin
                        w_state = FETCH_LO;
                    end
                end
            end
            FETCH_LO: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_pc;
                if (bus.mem_rvalid) begin
                    w_pc    = r_pc + 1'b1;
                    w_lo    = bus.mem_data;
                    w_state = ISSUE;
                    case (w_cur_mode)
                        AM_IMM, AM_REL: w_operand  = bus.mem_data;
                        AM_ZPG:         w_eff_addr = ADDR_WIDTH'(bus.mem_data);
                        AM_ZPX:         w_eff_addr = ADDR_WIDTH'(w_zpx);
                        AM_ABS, AM_ABX, AM_ABY: w_state = FETCH_HI;
                        AM_INDX: begin
                            w_ptr   = w_zpx;
                            w_state = PTR_LO;
                        end
                        AM_INDY: begin
                            w_ptr   = bus.mem_data;
                            w_state = PTR_LO;
                        end
                        default: w_state = ISSUE;
                    endcase
                end
            end
            FETCH_HI: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = r_pc;
                if (bus.mem_rvalid) begin
                    w_pc       = r_pc + 1'b1;
                    w_eff_addr = w_abs_sum;
                    w_state    = ISSUE;
                end
            end
            PTR_LO: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = ADDR_WIDTH'(r_ptr);
                if (bus.mem_rvalid) begin
                    w_lo    = bus.mem_data;
                    w_state = PTR_HI;
                end
            end
            PTR_HI: begin
                w_mem_rd   = 1'b1;
                w_mem_addr = ADDR_WIDTH'(w_ptr_next);
                if (bus.mem_rvalid) begin
                    w_eff_addr = w_ind_sum;
                    w_state    = ISSUE;
                end
            end
            ISSUE: begin
                w_ready = 1'b1;
                w_state = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.instruction_done) begin
                    w_ready = 1'b0;
                    w_state = run ? FETCH_OP : IDLE;
                end
            end
            HALT: begin
                w_state = HALT;
            end
            default: w_state = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instruction <= '0;
            r_operand     <= '0;
            r_eff_addr    <= '0;
            r_ready       <= 1'b0;
            r_fault       <= 1'b0;
            r_lo          <= '0;
            r_ptr         <= '0;
        end else begin
            r_state       <= w_state;
            r_pc          <= w_pc;
            r_instruction <= w_instruction;
            r_operand     <= w_operand;
            r_eff_addr    <= w_eff_addr;
            r_ready       <= w_ready;
            r_fault       <= w_fault;
            r_lo          <= w_lo;
            r_ptr         <= w_ptr;
        end
    end

    // Read request is decoded from state, so reset drops a pending read at once.
    assign bus.mem_rd            = w_mem_rd;
    assign bus.mem_addr          = w_mem_addr;
    assign bus.instruction       = r_instruction;
    assign bus.operand           = r_operand;
    assign bus.eff_addr          = r_eff_addr;
    assign bus.instruction_ready = r_ready;
    assign pc                    = r_pc;
    assign fault                 = r_fault;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Front-end controller that sequences the decoder.
- Fetches the opcode at PC and the operand bytes its addressing mode needs, and resolves indirect pointers.
- Computes the effective address, presents opcode plus operand to the decoder with instruction_ready, then waits for instruction_done before advancing PC.
- Sits between the memory read port, the X/Y registers and the decoder; sole owner of PC during fetch.

Parameters:
- REG_WIDTH, 8, data/register width
- ADDR_WIDTH, 16, address width
- RESET_PC, 16'h0600, PC value loaded on reset

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- run  in  1  level; sequencer fetches while high
- mem_addr  out  ADDR_WIDTH  read address
- mem_rd  out  1  read request
- mem_data  in  REG_WIDTH  read data
- mem_rvalid  in  1  read data valid
- x_in  in  REG_WIDTH  X register value
- y_in  in  REG_WIDTH  Y register value
- instruction  out  REG_WIDTH  latched opcode
- operand  out  REG_WIDTH  immediate/relative byte (0 if none)
- eff_addr  out  ADDR_WIDTH  resolved effective address (0 if none)
- instruction_ready  out  1  operands valid to decoder
- instruction_done  in  1  decoder finished current instruction
- pc  out  ADDR_WIDTH  program counter
- fault  out  1  sticky illegal-opcode flag

Behaviour:
- Reset (async, reset_n low): state IDLE; pc=RESET_PC; mem_addr=0, mem_rd=0, instruction=0, operand=0, eff_addr=0, instruction_ready=0, fault=0.
- States: IDLE, FETCH_OP, FETCH_LO, FETCH_HI, PTR_LO, PTR_HI, ISSUE, WAIT_DONE, HALT.
- Read handshake: in each fetch state, mem_rd=1 and mem_addr is held stable until mem_rvalid=1 is sampled. mem_data is latched in that same cycle. mem_rvalid is ignored when mem_rd=0. Arbitrary wait states are allowed.
- IDLE -> FETCH_OP when run=1.
- FETCH_OP: reads pc. On rvalid: latch instruction, pc+=1, clear operand and eff_addr. Decode mode = opcode[4:2], cc = opcode[1:0].
- cc=11: fault=1 -> HALT. HALT is left only by reset.
- Mode table, cc=01 (operand bytes):
  - 000 (zp,X) 1
  - 001 zpg 1
  - 010 imm 1
  - 011 abs 2
  - 100 (zp),Y 1
  - 101 zpg,X 1
  - 110 abs,Y 2
  - 111 abs,X 2
- Mode table, cc=00/10:
  - 000 imm 1
  - 001 zpg 1
  - 010 implied 0
  - 011 abs 2
  - 100 relative 1 (goes to operand)
  - 101 zpg,X 1
  - 110 implied 0
  - 111 abs,X 2
  - All indexing uses X in this revision.
- Zero operand bytes -> ISSUE. Otherwise -> FETCH_LO.
- FETCH_LO reads pc; pc+=1. Imm/relative: operand=byte -> ISSUE. Two-byte modes -> FETCH_HI. Indirect modes -> PTR_LO. Others -> ISSUE.
- FETCH_HI reads pc; pc+=1 -> ISSUE.
- Effective address:
  - zpg: {00,lo}
  - zpg,X: {00,(lo+X) mod 256}
  - abs: {hi,lo}
  - abs,X / abs,Y: ({hi,lo}+index) mod 2^16
- (zp,X): ptr=(lo+X) mod 256. PTR_LO reads {00,ptr}. PTR_HI reads {00,(ptr+1) mod 256}. eff_addr={hi,lo}.
- (zp),Y: ptr=lo; same two reads; eff_addr=({hi,lo}+Y) mod 2^16.
- Zero-page pointer reads never carry into the high byte.
- ISSUE: instruction_ready=1 -> WAIT_DONE.
- WAIT_DONE: hold instruction_ready, instruction, operand and eff_addr stable. On instruction_done=1: instruction_ready=0, then -> FETCH_OP if run=1, else IDLE.
- instruction_ready is low for at least 1 cycle between instructions, so each instruction produces a fresh rising edge.
- run falling mid-fetch: the current instruction completes through WAIT_DONE, then the sequencer goes to IDLE.
- instruction_done outside WAIT_DONE is ignored.
- pc wraps FFFF->0000.
- Reset asserted mid-operation aborts immediately to reset values, including a pending read.

Test Plan:
- Reset; run=1; mem[0600..0601]=A9,42 with 1-wait memory -> instruction=A9, operand=42, eff_addr=0000, ready=1. Pulse instruction_done -> ready=0, pc=0602, next read at 0602.
- 75,10 with X=05 -> eff_addr=0015. Repeat with X=F5 -> eff_addr=0005 (zero-page wrap), pc advances by 2.
- B1,20 with mem[0020]=FE, mem[0021]=12, Y=03 -> reads 0020 then 0021, eff_addr=1301. Then 81,FF with X=00, mem[00FF]=34, mem[0000]=56 -> second pointer read at 0000, eff_addr=5634.
- 9D,FF,FF with X=02 -> eff_addr=0001 (16-bit wrap), pc+=3. Opcode EA (cc=10, mode 010) -> no operand reads, ready after the opcode read, pc+=1.
- Opcode 03 -> fault=1, state HALT, mem_rd=0 thereafter. Run instruction_done/run stimulus -> no change. reset_n low -> fault=0, pc=0600.
- Hold mem_rvalid low 5 cycles during FETCH_HI -> mem_addr/mem_rd stable. Assert reset_n low during WAIT_DONE -> ready=0 asynchronously, pc=0600.
